calc_alu: RTL and testbench

CALC_ALU -- requirements
Module: calc_alu

---
 rtl/calc_pkg.sv | 20 ++
 rtl/calc_alu.sv | 163 ++++++++++++++++
 tb/tb_calc_alu.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator: operation codes, FSM
// states and the default operand width used by entry, ALU and display.
package calc_pkg;

   localparam int WIDTH = 20;

   typedef enum logic [1:0] {
      ADD = 2'd0,
      SUB = 2'd1,
      MUL = 2'd2,
      DIV = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/calc_alu.sv
// Calculator ALU: single-cycle ADD/SUB, iterative shift-add MUL and
// restoring DIV, one iteration per clock, with a one-cycle done pulse.
module calc_alu #(
   parameter int WIDTH = calc_pkg::WIDTH
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result,
   output logic [WIDTH-1:0]     rem,
   output logic                 neg,
   output logic                 err
);

   import calc_pkg::*;

   state_t               state;
   state_t               state_nx;
   op_t                  op_in;
   op_t                  op_r;
   logic [WIDTH-1:0]     b_r;
   logic [2*WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]     shreg;
   logic [2*WIDTH:0]     acc;
   logic [4:0]           cnt;

   logic                 is_add;
   logic                 is_sub;
   logic                 is_dz;
   logic                 fast;
   logic                 last;
   logic [2*WIDTH:0]     sum_ab;
   logic                 lt;
   logic [WIDTH-1:0]     diff;

   logic [2*WIDTH:0]     mul_acc;
   logic [WIDTH:0]       div_sh;
   logic [WIDTH:0]       div_try;
   logic                 div_ge;
   logic [WIDTH-1:0]     div_rem;
   logic [WIDTH-1:0]     div_quo;

   assign op_in  = op_t'(op);
   assign is_add = (op_in == ADD);
   assign is_sub = (op_in == SUB);
   assign is_dz  = (op_in == DIV) && (b == '0);
   assign fast   = is_add || is_sub || is_dz;
   assign last   = (cnt == 5'(WIDTH - 1));

   assign sum_ab = (2*WIDTH+1)'(a) + (2*WIDTH+1)'(b);
   assign lt     = (a < b);
   assign diff   = lt ? (b - a) : (a - b);

   assign busy = (state == RUN);
   assign done = (state == DONE);

   // One MUL step (LSB first) and one restoring DIV step (MSB first).
   // For DIV, acc holds the partial remainder and shreg the dividend
   // being shifted out while quotient bits shift in from the right.
   always_comb begin
      mul_acc = acc + (shreg[0] ? {1'b0, mcand} : '0);
      div_sh  = {acc[WIDTH-1:0], shreg[WIDTH-1]};
      div_try = div_sh - {1'b0, b_r};
      div_ge  = ~div_try[WIDTH];
      div_rem = div_ge ? div_try[WIDTH-1:0] : div_sh[WIDTH-1:0];
      div_quo = {shreg[WIDTH-2:0], div_ge};
   end

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = fast ? DONE : RUN;
         RUN:     if (last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         op_r   <= ADD;
         b_r    <= '0;
         mcand  <= '0;
         shreg  <= '0;
         acc    <= '0;
         cnt    <= '0;
         result <= '0;
         rem    <= '0;
         neg    <= 1'b0;
         err    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  op_r  <= op_in;
                  b_r   <= b;
                  mcand <= (2*WIDTH)'(a);
                  shreg <= (op_in == MUL) ? b : a;
                  acc   <= '0;
                  cnt   <= '0;
                  unique case (1'b1)
                     is_add: begin
                        result <= sum_ab[2*WIDTH-1:0];
                        rem    <= '0;
                        neg    <= 1'b0;
                        err    <= 1'b0;
                     end
                     is_sub: begin
                        result <= (2*WIDTH)'(diff);
                        rem    <= '0;
                        neg    <= lt;
                        err    <= 1'b0;
                     end
                     is_dz: begin
                        result <= '0;
                        rem    <= '0;
                        neg    <= 1'b0;
                        err    <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            RUN: begin
               cnt <= cnt + 5'd1;
               if (op_r == MUL) begin
                  acc   <= mul_acc;
                  mcand <= mcand << 1;
                  shreg <= shreg >> 1;
               end else begin
                  acc   <= (2*WIDTH+1)'(div_rem);
                  shreg <= div_quo;
               end
               if (last) begin
                  cnt <= '0;
                  neg <= 1'b0;
                  err <= 1'b0;
                  if (op_r == MUL) begin
                     result <= mul_acc[2*WIDTH-1:0];
                     rem    <= '0;
                  end else begin
                     result <= (2*WIDTH)'(div_quo);
                     rem    <= div_rem;
                  end
               end
            end
            DONE: ;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_alu.sv
// Self-checking bench for calc_alu: directed vector table, hand-written
// reset/start corner sequences and random operations against a model.
module tb_calc_alu;

   localparam int W = 20;

   logic            CLK;
   logic            RST;
   logic            start;
   logic [1:0]      op;
   logic [W-1:0]    a;
   logic [W-1:0]    b;
   logic            busy;
   logic            done;
   logic [2*W-1:0]  result;
   logic [W-1:0]    rem;
   logic            neg;
   logic            err;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string          tag;
      logic [1:0]     op;
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] res;
      logic [W-1:0]   rem;
      logic           neg;
      logic           err;
      int             lat;
   } vec_t;

   vec_t tbl[12];

   calc_alu #(.WIDTH(W)) dut (
      .CLK(CLK),
      .RST(RST),
      .start(start),
      .op(op),
      .a(a),
      .b(b),
      .busy(busy),
      .done(done),
      .result(result),
      .rem(rem),
      .neg(neg),
      .err(err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: plain arithmetic on 64-bit integers; lat is the number
   // of edges after the capturing edge before done appears.
   function automatic void model(input logic [1:0] o,
                                 input longint unsigned x,
                                 input longint unsigned y,
                                 output longint unsigned r,
                                 output longint unsigned m,
                                 output logic n, output logic e,
                                 output int l);
      r = 0; m = 0; n = 1'b0; e = 1'b0; l = 0;
      case (o)
         2'd0: r = x + y;
         2'd1: begin n = (x < y); r = n ? y - x : x - y; end
         2'd2: begin r = x * y; l = W; end
         default: begin
            if (y == 0) e = 1'b1;
            else begin r = x / y; m = x % y; l = W; end
         end
      endcase
   endfunction

   task automatic run_op(input string tag, input logic [1:0] o,
                         input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [2*W-1:0] er, input logic [W-1:0] erm,
                         input logic en, input logic ee, input int elat);
      int lat;
      int bc;
      @(negedge CLK);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge CLK); #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); op = 2'($urandom);
      lat = 0; bc = 0;
      while (!done && lat < 100) begin
         if (busy) bc++;
         @(posedge CLK); #1;
         lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'(elat));
      chk({tag, "_busy"}, 64'(bc), 64'(elat));
      chk({tag, "_res"}, 64'(result), 64'(er));
      chk({tag, "_rem"}, 64'(rem), 64'(erm));
      chk({tag, "_neg"}, 64'(neg), 64'(en));
      chk({tag, "_err"}, 64'(err), 64'(ee));
      @(posedge CLK); #1;
      chk({tag, "_done_once"}, 64'(done), 64'd0);
      chk({tag, "_hold"}, 64'(result), 64'(er));
   endtask

   initial begin
      longint unsigned mr, mm;
      logic mn, me;
      int ml;
      logic [1:0] ro;
      logic [W-1:0] ra, rb;
      int dcnt, bcnt, guard;

      tbl[0]  = '{"add_req",  2'd0, 20'd600000,  20'd700000, 40'd1300000, 20'd0, 1'b0, 1'b0, 0};
      tbl[1]  = '{"sub_neg",  2'd1, 20'd5,       20'd12,     40'd7,       20'd0, 1'b1, 1'b0, 0};
      tbl[2]  = '{"sub_pos",  2'd1, 20'd12,      20'd5,      40'd7,       20'd0, 1'b0, 1'b0, 0};
      tbl[3]  = '{"mul_max",  2'd2, 20'd1048575, 20'd1048575, 40'd1099509530625, 20'd0, 1'b0, 1'b0, 20};
      tbl[4]  = '{"div_req",  2'd3, 20'd1000000, 20'd7,      40'd142857,  20'd1, 1'b0, 1'b0, 20};
      tbl[5]  = '{"div_zero", 2'd3, 20'd9,       20'd0,      40'd0,       20'd0, 1'b0, 1'b1, 0};
      tbl[6]  = '{"add_max",  2'd0, 20'd1048575, 20'd1048575, 40'd2097150, 20'd0, 1'b0, 1'b0, 0};
      tbl[7]  = '{"sub_eq",   2'd1, 20'd5,       20'd5,      40'd0,       20'd0, 1'b0, 1'b0, 0};
      tbl[8]  = '{"div_small",2'd3, 20'd3,       20'd10,     40'd0,       20'd3, 1'b0, 1'b0, 20};
      tbl[9]  = '{"div_one",  2'd3, 20'd1048575, 20'd1,      40'd1048575, 20'd0, 1'b0, 1'b0, 20};
      tbl[10] = '{"mul_zero", 2'd2, 20'd0,       20'd12345,  40'd0,       20'd0, 1'b0, 1'b0, 20};
      tbl[11] = '{"div_max",  2'd3, 20'd1048575, 20'd1048575, 40'd1,      20'd0, 1'b0, 1'b0, 20};

      RST = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset_outs", 64'({busy, done, neg, err, result, rem}), 64'd0);
      @(negedge CLK);
      RST = 1'b0;

      foreach (tbl[i])
         run_op(tbl[i].tag, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res,
                tbl[i].rem, tbl[i].neg, tbl[i].err, tbl[i].lat);

      // Reset in the middle of a MUL, with non-zero outputs still held.
      run_op("pre_rst", 2'd1, 20'd5, 20'd12, 40'd7, 20'd0, 1'b1, 1'b0, 0);
      @(negedge CLK);
      start = 1'b1; op = 2'd2; a = 20'd1048575; b = 20'd1048575;
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (10) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1; start = 1'b1;
      @(posedge CLK); #1;
      chk("rst_mid_outs", 64'({busy, done, neg, err, result, rem}), 64'd0);
      @(negedge CLK);
      RST = 1'b0; start = 1'b0;
      @(posedge CLK); #1;
      chk("rst_no_start", 64'({busy, done}), 64'd0);
      run_op("mul_after_rst", 2'd2, 20'd3, 20'd4, 40'd12, 20'd0, 1'b0, 1'b0, 20);

      // Start pulses during RUN and during DONE must be dropped.
      @(negedge CLK);
      start = 1'b1; op = 2'd2; a = 20'd3; b = 20'd5;
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (5) @(posedge CLK);
      @(negedge CLK);
      start = 1'b1; op = 2'd0; a = 20'd1; b = 20'd1;
      @(negedge CLK);
      start = 1'b0;
      guard = 0;
      while (!done && guard < 100) begin
         @(posedge CLK); #1;
         guard++;
      end
      chk("run_start_wait", 64'(guard < 100), 64'd1);
      chk("run_start_res", 64'(result), 64'd15);
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      dcnt = 0; bcnt = 0;
      repeat (30) begin
         @(posedge CLK); #1;
         if (done) dcnt++;
         if (busy) bcnt++;
      end
      chk("no_second_done", 64'(dcnt), 64'd0);
      chk("no_queued_busy", 64'(bcnt), 64'd0);
      chk("run_start_hold", 64'(result), 64'd15);

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom);
         ra = W'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         model(ro, 64'(ra), 64'(rb), mr, mm, mn, me, ml);
         run_op($sformatf("rnd%0d", i), ro, ra, rb, (2*W)'(mr), W'(mm),
                mn, me, ml);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
